bus_master: RTL
===============

# bus_master

Serial-bus initiator: the transmitting end of the slave protocol used by the display and memory slaves. Accepts a parallel read or write command from a local module, requests the bus from the arbiter, and serialises slave ID, direction, address and write data onto `data_bus_serial`. For reads it releases the line and deserialises the slave's reply. Sits between a processor/controller module and the shared bus/arbiter.

## Interface
- `ADDRESS_WIDTH`, 15, address bits per frame
- `DATA_WIDTH`, 8, data bits per frame
- `TIMEOUT`, 255, max cycles waiting for a read reply start bit (1..255)

- `clk`  in  1  bus clock; all logic on rising edge
- `rstn`  in  1  **asynchronous, active-low reset**
- `start`  in  1  command strobe; sampled only in IDLE
- `rd_wrt`  in  1  1 = write, 0 = read
- `slave_id`  in  2  target slave ID
- `address`  in  ADDRESS_WIDTH  target address
- `data_in`  in  DATA_WIDTH  write data
- `data_out`  out  DATA_WIDTH  last read data
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `timeout_err`  out  1  valid with `done`; read got no reply
- `bus_request`  out  1  request to arbiter
- `bus_grant`  in  1  grant from arbiter
- `bus_util`  out  1  frame-active strobe to all slaves
- `data_bus_serial`  inout  1  shared serial line; driven only in master-drive states, else `z`

## Operation
- States: IDLE, REQ, ID, RW, ADDR, WDATA, TURN, WAIT, RDATA, DONE.
- IDLE: `start`=1 latches `rd_wrt`, `slave_id`, `address`, `data_in`; -> REQ. `busy`=1 from next cycle.
- REQ: `bus_request`=1; on `bus_grant`=1 -> ID.
- ID (2 cycles): drive `slave_id` MSB first. RW (1 cycle): drive latched `rd_wrt`. ADDR (ADDRESS_WIDTH cycles): address LSB first.
- Write: WDATA (DATA_WIDTH cycles), data LSB first -> DONE.
- Read: TURN (1 cycle), line released -> WAIT. WAIT: line sampled each cycle; `=== 1'b1` is the slave's start bit -> RDATA. After TIMEOUT cycles in WAIT without it -> DONE with `timeout_err`. RDATA (DATA_WIDTH cycles): sample LSB first into shift register. On last bit, `data_out` updates -> DONE.
- DONE (1 cycle): `done`=1; `timeout_err` set if timed out; `bus_util`=0, `bus_request`=0, line `z`, `busy`=0 -> IDLE.
- `bus_util`=1 in ID through RDATA inclusive, 0 elsewhere. `bus_request` stays 1 from REQ through the last frame state.
- Bit counter sized for max(ADDRESS_WIDTH, DATA_WIDTH). Wait counter 8 bits, reset on WAIT entry.

## Timing
- Reset (async, immediate): state IDLE, `data_out`=0, `busy`=0, `done`=0, `timeout_err`=0, `bus_request`=0, `bus_util`=0, line `z`, shift/counters 0.
- One bit per clock. Each driven bit is stable from one rising edge to the next. Slaves sample on the following edge.
- Write frame: `bus_util` high exactly 2+1+ADDRESS_WIDTH+DATA_WIDTH = 26 cycles (defaults).
- Latency from `start` to `done` with grant already high:
  - write: 1 (REQ) + 26 + 1 = 28 cycles.
  - read: 1 + 18 + 1 (TURN) + w + 1 (start-bit cycle) + 8 + 1, where w = WAIT cycles before the start bit.
- `start` while `busy`: ignored, no queuing. `start` asserted in DONE's cycle: ignored.
- `bus_grant` deasserted mid-frame: ignored; frame completes. The arbiter must not preempt.
- `rstn` low mid-frame: line released and `bus_util` dropped asynchronously. Partial frame abandoned; `data_out` cleared.
- Timeout: `done` and `timeout_err` both high in the same cycle, and `data_out` unchanged.

## Test plan
- Write: id=2'b00, addr=15'h0005, data=8'hA5, grant tied 1 -> line sequence 0,0,1,1,0,1,0…(addr 15 bits),1,0,1,0,0,1,0,1. `bus_util` high 26 cycles. `done` at cycle 28 after `start`.
- Read: id=2'b01, addr=15'h7FFF. Bench slave drives start bit after 3 WAIT cycles, then 8'h3C LSB first -> `data_out`=8'h3C, `timeout_err`=0. Line `z` from TURN onward.
- Read, no reply -> `done` and `timeout_err` pulse exactly TIMEOUT cycles after WAIT entry. `data_out` holds the previous value 8'h3C.
- Grant held low 10 cycles, then high -> `bus_request` high throughout. No `bus_util` until the cycle after grant. Grant dropped at address bit 5 -> frame still completes.
- `start` re-pulsed during an active write with different data -> ignored; the serialised data matches the original command.
- `rstn` pulsed low at write bit 12 -> `bus_util`=0 and line `z` immediately. `busy`=0. A fresh write after release completes normally.

Source files
------------

// File: rtl/bus_master.sv
// bus_master: serial-bus initiator; frames slave ID, direction, address and write data
// onto a shared one-wire line and deserialises the slave's read reply.
module bus_master #(
   parameter int ADDRESS_WIDTH = 15,
   parameter int DATA_WIDTH    = 8,
   parameter int TIMEOUT       = 255
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic                     rd_wrt,
   input  logic [1:0]               slave_id,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout_err,
   output logic                     bus_request,
   input  logic                     bus_grant,
   output logic                     bus_util,
   inout  wire                      data_bus_serial
);
   localparam int MAXW = ADDRESS_WIDTH > DATA_WIDTH ? ADDRESS_WIDTH : DATA_WIDTH;
   localparam int CW   = $clog2(MAXW + 1);
   localparam int AIW  = $clog2(ADDRESS_WIDTH);
   localparam int DIW  = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] A_LAST = CW'(ADDRESS_WIDTH - 1);
   localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [7:0]    W_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [3:0] {IDLE, REQ, ID, RW, ADDR, WDATA, TURN, WAIT, RDATA, DONE} state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [7:0]               wcnt_q, wcnt_d;
   logic                     wr_q;
   logic [1:0]               id_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    wdata_q, rx_q, rx_d, dout_q;
   logic                     act_q, act_d, util_q, util_d, drv_q, drv_d, sdo_q, sdo_d;
   logic                     done_q, tout_q, sdi;

   always_comb begin
      sdi     = (data_bus_serial === 1'b1);
      rx_d    = {sdi, rx_q[DATA_WIDTH-1:1]};
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      wcnt_d  = wcnt_q + 8'd1;
      unique case (state_q)
         IDLE:    if (start) state_d = REQ;
         REQ:     if (bus_grant) state_d = ID;
         ID:      if (cnt_q[0]) state_d = RW;
         RW:      state_d = ADDR;
         ADDR:    if (cnt_q == A_LAST) state_d = wr_q ? WDATA : TURN;
         WDATA:   if (cnt_q == D_LAST) state_d = DONE;
         TURN:    state_d = WAIT;
         WAIT:    if (sdi) state_d = RDATA; else if (wcnt_q == W_LAST) state_d = DONE;
         RDATA:   if (cnt_q == D_LAST) state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         cnt_d  = '0;
         wcnt_d = '0;
      end
      // line value is chosen for the state being entered so it is stable for the whole bit cycle
      sdo_d  = (state_d == ID)    ? id_q[~cnt_d[0]] :
               (state_d == RW)    ? wr_q :
               (state_d == ADDR)  ? addr_q[cnt_d[AIW-1:0]] :
               (state_d == WDATA) ? wdata_q[cnt_d[DIW-1:0]] : 1'b0;
      drv_d  = state_d inside {ID, RW, ADDR, WDATA};
      act_d  = state_d != IDLE && state_d != DONE;
      util_d = act_d && state_d != REQ;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         wr_q    <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         act_q   <= 1'b0;
         util_q  <= 1'b0;
         drv_q   <= 1'b0;
         sdo_q   <= 1'b0;
         done_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         if (state_q == IDLE && start) begin
            wr_q    <= rd_wrt;
            id_q    <= slave_id;
            addr_q  <= address;
            wdata_q <= data_in;
         end
         if (state_q == RDATA) rx_q <= rx_d;
         if (state_q == RDATA && state_d == DONE) dout_q <= rx_d;
         act_q   <= act_d;
         util_q  <= util_d;
         drv_q   <= drv_d;
         sdo_q   <= sdo_d;
         done_q  <= state_d == DONE;
         tout_q  <= state_d == DONE && state_q == WAIT;
      end
   end

   assign data_bus_serial = drv_q ? sdo_q : 1'bz;
   assign data_out        = dout_q;
   assign busy            = act_q;
   assign bus_request     = act_q;
   assign bus_util        = util_q;
   assign done            = done_q;
   assign timeout_err     = tout_q;
endmodule
